// File: rtl/mux8x1_rr_arbiter.sv
// Round-robin arbiter and sequencer for an 8-lane mux: picks a requesting lane,
// captures its word and delivers it downstream over a valid/ready handshake.
module mux8x1_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           req,
    input  logic [8*WIDTH-1:0]   data_in,
    output logic [2:0]           select,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           gnt
);
    localparam int CW = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] BMAX = CW'(BURST_MAX);

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q, state_d;
    logic [2:0]        last_q, last_d;
    logic [2:0]        select_q, select_d;
    logic [CW-1:0]     burst_cnt_q, burst_cnt_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;

    logic [2:0]        scan_win;
    logic              lock;
    logic [2:0]        winner;

    // Rotating priority: last+1 first, last itself only after a full wrap.
    always_comb begin
        logic       found;
        logic [2:0] idx;
        scan_win = last_q;
        found    = 1'b0;
        idx      = last_q;
        for (int i = 1; i <= 8; i++) begin
            idx = last_q + 3'(i);
            if (!found && req[idx]) begin
                scan_win = idx;
                found    = 1'b1;
            end
        end
    end

    assign lock   = req[last_q] && (burst_cnt_q < BMAX);
    assign winner = lock ? last_q : scan_win;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        select_d    = select_q;
        burst_cnt_d = burst_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d     = SEND;
                    out_valid_d = 1'b1;
                    select_d    = winner;
                    last_d      = winner;
                    out_data_d  = data_in[int'(winner)*WIDTH +: WIDTH];
                    burst_cnt_d = lock ? burst_cnt_q + CW'(1) : CW'(1);
                end
            end
            SEND: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 3'd7;
            select_q    <= 3'd0;
            burst_cnt_q <= BMAX;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            select_q    <= select_d;
            burst_cnt_q <= burst_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign select    = select_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign gnt       = (out_valid_q && out_ready) ? (8'b1 << select_q) : 8'b0;

endmodule

// File: tb/tb_mux8x1_rr_arbiter.sv
// Bench for mux8x1_rr_arbiter: three instances (BURST_MAX 1, 2, 4) share stimulus and
// are compared every cycle against a behavioural round-robin model.
module tb_mux8x1_rr_arbiter;
    logic        clk;
    logic        rst;
    logic [7:0]  req;
    logic [63:0] data_in;
    logic        out_ready;

    logic [2:0]  sel [3];
    logic [7:0]  od  [3];
    logic        ov  [3];
    logic [7:0]  gnt [3];

    int nvec = 0;
    int nerr = 0;

    int          bm     [3] = '{1, 2, 4};
    int          m_last [3];
    int          m_cnt  [3];
    int          m_sel  [3];
    logic [7:0]  m_od   [3];
    bit          m_v    [3];

    int gq0[$];
    int gq1[$];
    int gq2[$];

    mux8x1_rr_arbiter #(.WIDTH(8), .BURST_MAX(1)) u_bm1 (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in), .select(sel[0]),
        .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready), .gnt(gnt[0]));
    mux8x1_rr_arbiter #(.WIDTH(8), .BURST_MAX(2)) u_bm2 (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in), .select(sel[1]),
        .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready), .gnt(gnt[1]));
    mux8x1_rr_arbiter #(.WIDTH(8), .BURST_MAX(4)) u_bm4 (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in), .select(sel[2]),
        .out_data(od[2]), .out_valid(ov[2]), .out_ready(out_ready), .gnt(gnt[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lane_of(input logic [7:0] g);
        int r = -1;
        for (int i = 0; i < 8; i++) if (g[i]) r = i;
        return r;
    endfunction

    task automatic push_g(input int k, input int lane);
        case (k)
            0: gq0.push_back(lane);
            1: gq1.push_back(lane);
            default: gq2.push_back(lane);
        endcase
    endtask

    task automatic clear_g();
        gq0.delete();
        gq1.delete();
        gq2.delete();
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_v[k] = 1'b0; m_sel[k] = 0; m_od[k] = 8'h00;
            m_last[k] = 7; m_cnt[k] = bm[k];
        end
    endtask

    // Called at posedge+1; asserts reset between edges and checks it acts at once.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_valid[%0d]", k), 64'(ov[k]), 64'h0);
            chk($sformatf("rst_gnt[%0d]", k), 64'(gnt[k]), 64'h0);
            chk($sformatf("rst_select[%0d]", k), 64'(sel[k]), 64'h0);
            chk($sformatf("rst_data[%0d]", k), 64'(od[k]), 64'h0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One clock: check combinational gnt, advance model on the edge, check registers.
    task automatic step();
        logic [7:0] eg;
        #1;
        for (int k = 0; k < 3; k++) begin
            eg = (m_v[k] && out_ready) ? (8'b1 << m_sel[k]) : 8'h00;
            chk($sformatf("gnt[%0d]", k), 64'(gnt[k]), 64'(eg));
            chk($sformatf("onehot[%0d]", k), 64'($countones(gnt[k]) > 1), 64'h0);
            if (gnt[k] != 8'h00) push_g(k, lane_of(gnt[k]));
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (!m_v[k]) begin
                if (req != 8'h00) begin
                    int w = -1;
                    if (req[m_last[k]] && m_cnt[k] < bm[k]) begin
                        w = m_last[k];
                        m_cnt[k]++;
                    end else begin
                        for (int i = 1; i <= 8; i++)
                            if (w < 0 && req[(m_last[k] + i) % 8]) w = (m_last[k] + i) % 8;
                        m_cnt[k] = 1;
                    end
                    m_sel[k]  = w;
                    m_last[k] = w;
                    m_od[k]   = data_in[w*8 +: 8];
                    m_v[k]    = 1'b1;
                end
            end else if (out_ready) begin
                m_v[k] = 1'b0;
            end
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("valid[%0d]", k), 64'(ov[k]), 64'(m_v[k]));
            chk($sformatf("select[%0d]", k), 64'(sel[k]), 64'(m_sel[k]));
            chk($sformatf("data[%0d]", k), 64'(od[k]), 64'(m_od[k]));
        end
    endtask

    task automatic rand_data();
        data_in = {$urandom, $urandom};
    endtask

    initial begin
        int exp4[9];
        rst = 1'b1; req = 8'h00; data_in = '0; out_ready = 1'b0;
        model_reset();
        do_reset();

        // Single lane 3 beat with immediate acceptance.
        clear_g();
        rand_data(); data_in[3*8 +: 8] = 8'hC5; req = 8'h08; out_ready = 1'b1;
        step();
        chk("t2_valid", 64'(ov[2]), 64'h1);
        chk("t2_select", 64'(sel[2]), 64'h3);
        chk("t2_data", 64'(od[2]), 64'hC5);
        req = 8'h00; rand_data();
        step();
        chk("t2_ngnt", 64'(gq2.size()), 64'h1);
        if (gq2.size() > 0) chk("t2_lane", 64'(gq2[0]), 64'h3);
        chk("t2_valid_after", 64'(ov[2]), 64'h0);

        // All lanes requesting, BURST_MAX=1 rotates 0..7,0.
        do_reset(); clear_g();
        req = 8'hFF; out_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin rand_data(); step(); end
        chk("t3_ngnt", 64'(gq0.size()), 64'd9);
        for (int i = 0; i < 9 && i < gq0.size(); i++)
            chk($sformatf("t3_lane%0d", i), 64'(gq0[i]), 64'(i % 8));

        // Lanes 0 and 4, BURST_MAX=4: bursts of four.
        do_reset(); clear_g();
        exp4 = '{0, 0, 0, 0, 4, 4, 4, 4, 0};
        req = 8'h11; out_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin rand_data(); step(); end
        chk("t4_ngnt", 64'(gq2.size()), 64'd9);
        for (int i = 0; i < 9 && i < gq2.size(); i++)
            chk($sformatf("t4_lane%0d", i), 64'(gq2[i]), 64'(exp4[i]));

        // Backpressure: lane 6 held for 5 cycles then accepted once.
        do_reset(); clear_g();
        rand_data(); req = 8'h40; out_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin rand_data(); step(); end
        chk("t5_valid", 64'(ov[2]), 64'h1);
        chk("t5_select", 64'(sel[2]), 64'h6);
        chk("t5_nogrant", 64'(gq2.size()), 64'h0);
        out_ready = 1'b1; req = 8'h00;
        step();
        out_ready = 1'b0;
        step();
        chk("t5_ngnt", 64'(gq2.size()), 64'h1);
        if (gq2.size() > 0) chk("t5_lane", 64'(gq2[0]), 64'h6);

        // Lone lane 0 at BURST_MAX=2 never starves, then lane 7 takes over at the limit.
        do_reset(); clear_g();
        req = 8'h01; out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin rand_data(); step(); end
        chk("t6_ngnt", 64'(gq1.size()), 64'd6);
        for (int i = 0; i < gq1.size(); i++) chk($sformatf("t6_lane%0d", i), 64'(gq1[i]), 64'h0);
        req = 8'h81;
        for (int i = 0; i < 2; i++) begin rand_data(); step(); end
        chk("t6_switch_n", 64'(gq1.size()), 64'd7);
        if (gq1.size() > 6) chk("t6_switch", 64'(gq1[6]), 64'h7);

        // Randomized traffic with a reset dropped in mid-run.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                do_reset();
                req = 8'h00;
                for (int j = 0; j < 3; j++) step();
            end
            req = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            rand_data();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
